// File: rtl/parallel_serializer_pkg.sv
// Purpose: shared types and sizing helpers for the parallel_serializer slice.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package parallel_serializer_pkg;

    // Controller state: waiting for a bundle, or streaming words out of it.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Word-index width for a bundle of n_samples words (n_samples >= 2).
    function automatic int idx_width(input int n_samples);
        return (n_samples <= 2) ? 1 : $clog2(n_samples);
    endfunction

    // Index of the final word in a bundle, used to detect end of bundle.
    function automatic int last_index(input int n_samples);
        return n_samples - 1;
    endfunction

endpackage

// File: rtl/parallel_serializer_ctrl.sv
// Purpose: FSM and word-index counter; owns the recv/send handshakes and the buffer load enable.
// Latency: word 0 is valid the cycle after a bundle is accepted, one word per send handshake after that.
// Backpressure: send_rdy low holds state and index; recv_rdy is low while a bundle is in flight.
//   With PARALLEL_SERIALIZER_BACK_TO_BACK_EN defined, recv_rdy also rises on the last word while send_rdy is high.
module parallel_serializer_ctrl
    import parallel_serializer_pkg::*;
#(
    parameter int N_SAMPLES = 8,
    parameter int IDX_W     = idx_width(N_SAMPLES)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             recv_val,
    output logic             recv_rdy,
    output logic             send_val,
    input  logic             send_rdy,
    output logic             load_en,
    output logic [IDX_W-1:0] index
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(last_index(N_SAMPLES));

    state_t state;
    logic   at_last;
    logic   send_fire;

    // Handshake decode; recv_rdy depends only on state/index/reset (and send_rdy when chaining bundles).
    always_comb begin
        at_last   = (index == LAST_IDX);
        send_fire = send_val && send_rdy;
        recv_rdy  = 1'b0;
        if (!reset) begin
            if (state == IDLE) begin
                recv_rdy = 1'b1;
            end
`ifdef PARALLEL_SERIALIZER_BACK_TO_BACK_EN
            // Last word leaving this cycle frees the buffer, so a new bundle can land on the same edge.
            else if (at_last && send_rdy) begin
                recv_rdy = 1'b1;
            end
`endif
        end
        load_en = recv_val && recv_rdy;
    end

    // FSM with registered send_val and index; index only advances on an accepted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            index    <= '0;
            send_val <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_en) begin
                        state    <= SEND;
                        index    <= '0;
                        send_val <= 1'b1;
                    end
                end
                SEND: begin
                    if (send_fire) begin
                        if (!at_last) begin
                            index <= index + 1'b1;
                        end else if (load_en) begin
                            // Chained bundle: restart at word 0 without leaving SEND.
                            index <= '0;
                        end else begin
                            state    <= IDLE;
                            index    <= '0;
                            send_val <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    index    <= '0;
                    send_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/parallel_serializer.sv
// Purpose: parallel-to-serial stage; one N_SAMPLES-word bundle in, one word per handshake out (word 0 first).
// Latency: word 0 appears one cycle after bundle acceptance; N_SAMPLES+1 cycles per bundle, N_SAMPLES with chaining.
// Backpressure: send_rdy low stalls the stream with send_msg held; recv_rdy stays low until the buffer drains.
//   Optional feature macro: PARALLEL_SERIALIZER_BACK_TO_BACK_EN (accept the next bundle on the last-word handshake).
module parallel_serializer
    import parallel_serializer_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_SAMPLES*BIT_WIDTH-1:0] recv_msg,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    output logic [BIT_WIDTH-1:0]           send_msg,
    output logic                           send_val,
    input  logic                           send_rdy
);

    localparam int IDX_W = idx_width(N_SAMPLES);

    logic                 load_en;
    logic [IDX_W-1:0]     index;
    logic [BIT_WIDTH-1:0] buf_words [N_SAMPLES];

    parallel_serializer_ctrl #(
        .N_SAMPLES (N_SAMPLES),
        .IDX_W     (IDX_W)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .load_en  (load_en),
        .index    (index)
    );

    // Capture the whole bundle on an accepted transfer; contents are only observed while send_val is high.
    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < N_SAMPLES; i++) begin
                buf_words[i] <= recv_msg[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    // Output word select; driven from registers only, so recv_* never reaches send_* combinationally.
    always_comb begin
        send_msg = buf_words[index];
    end

endmodule

// File: tb/tb_parallel_serializer.sv
module tb_parallel_serializer;

    logic         clk;
    logic         reset;
    logic [127:0] recv_msg_a;
    logic [63:0]  recv_msg_b;
    logic         recv_val_v [2];
    logic         recv_rdy_v [2];
    logic [31:0]  send_msg_v [2];
    logic         send_val_v [2];
    logic         send_rdy_v [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: per-instance FIFO of words still owed downstream.
    logic [31:0] mem [2][1024];
    int          head [2];
    int          tail [2];

    parallel_serializer #(.BIT_WIDTH(32), .N_SAMPLES(4)) dut_a (
        .clk(clk), .reset(reset), .recv_msg(recv_msg_a),
        .recv_val(recv_val_v[0]), .recv_rdy(recv_rdy_v[0]),
        .send_msg(send_msg_v[0]), .send_val(send_val_v[0]), .send_rdy(send_rdy_v[0])
    );

    parallel_serializer #(.BIT_WIDTH(32), .N_SAMPLES(2)) dut_b (
        .clk(clk), .reset(reset), .recv_msg(recv_msg_b),
        .recv_val(recv_val_v[1]), .recv_rdy(recv_rdy_v[1]),
        .send_msg(send_msg_v[1]), .send_val(send_val_v[1]), .send_rdy(send_rdy_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nsamp(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic logic [31:0] bundle_word(input int k, input int i);
        return (k == 0) ? recv_msg_a[i*32 +: 32] : recv_msg_b[i*32 +: 32];
    endfunction

    // A bundle is accepted when nothing is owed, or (chaining) when only the last word is leaving now.
    function automatic logic exp_recv_rdy(input int k);
        int pend;
        pend = tail[k] - head[k];
        if (reset) return 1'b0;
        if (pend == 0) return 1'b1;
`ifdef PARALLEL_SERIALIZER_BACK_TO_BACK_EN
        if (pend == 1 && send_rdy_v[k]) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model update on each edge using the inputs that were valid during the closing cycle.
    always @(posedge clk) begin : model
        logic acc;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                head[k] = 0;
                tail[k] = 0;
            end else begin
                acc = recv_val_v[k] && exp_recv_rdy(k);
                if (tail[k] != head[k] && send_rdy_v[k]) head[k]++;
                if (acc) begin
                    for (int i = 0; i < nsamp(k); i++) begin
                        mem[k][tail[k] % 1024] = bundle_word(k, i);
                        tail[k]++;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk((k == 0) ? "model_send_val_a" : "model_send_val_b",
                    32'(send_val_v[k]), 32'(tail[k] != head[k]));
                chk((k == 0) ? "model_recv_rdy_a" : "model_recv_rdy_b",
                    32'(recv_rdy_v[k]), 32'(exp_recv_rdy(k)));
                if (tail[k] != head[k]) begin
                    chk((k == 0) ? "model_send_msg_a" : "model_send_msg_b",
                        send_msg_v[k], mem[k][head[k] % 1024]);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        recv_msg_a    = '0;
        recv_msg_b    = '0;
        recv_val_v[0] = 1'b0;
        recv_val_v[1] = 1'b0;
        send_rdy_v[0] = 1'b1;
        send_rdy_v[1] = 1'b1;
        head[0] = 0; head[1] = 0; tail[0] = 0; tail[1] = 0;

        // Reset state
        step();
        step();
        chk_en = 1'b1;
        chk("reset_send_val", 32'(send_val_v[0]), 32'd0);
        chk("reset_recv_rdy", 32'(recv_rdy_v[0]), 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_recv_rdy", 32'(recv_rdy_v[0]), 32'd1);

        // Basic bundle, send_rdy held high
        recv_msg_a    = {32'h44, 32'h33, 32'h22, 32'h11};
        recv_val_v[0] = 1'b1;
        step();
        recv_val_v[0] = 1'b0;
        chk("t1_w0", send_msg_v[0], 32'h11);
        chk("t1_val", 32'(send_val_v[0]), 32'd1);
        chk("t1_busy_rdy", 32'(recv_rdy_v[0]), 32'd0);
        step(); chk("t1_w1", send_msg_v[0], 32'h22);
        step(); chk("t1_w2", send_msg_v[0], 32'h33);
        step(); chk("t1_w3", send_msg_v[0], 32'h44);
        step();
        chk("t1_idle_rdy", 32'(recv_rdy_v[0]), 32'd1);
        chk("t1_idle_val", 32'(send_val_v[0]), 32'd0);

        // Stall on word 1 for two cycles
        recv_val_v[0] = 1'b1;
        step();
        recv_val_v[0] = 1'b0;
        chk("t2_w0", send_msg_v[0], 32'h11);
        step(); send_rdy_v[0] = 1'b0;
        chk("t2_w1_c2", send_msg_v[0], 32'h22);
        step();
        chk("t2_w1_c3", send_msg_v[0], 32'h22);
        chk("t2_w1_c3_val", 32'(send_val_v[0]), 32'd1);
        step(); send_rdy_v[0] = 1'b1;
        chk("t2_w1_c4", send_msg_v[0], 32'h22);
        step(); chk("t2_w2", send_msg_v[0], 32'h33);
        step(); chk("t2_w3_t6", send_msg_v[0], 32'h44);
        step(); chk("t2_idle_val", 32'(send_val_v[0]), 32'd0);

        // recv_msg changes while a bundle is in flight
        recv_msg_a    = {32'h44, 32'h33, 32'h22, 32'h11};
        recv_val_v[0] = 1'b1;
        step();
        recv_msg_a = {4{32'hDEADBEEF}};
        chk("t3_w0", send_msg_v[0], 32'h11);
        chk("t3_rdy0", 32'(recv_rdy_v[0]), 32'd0);
        step(); chk("t3_w1", send_msg_v[0], 32'h22);
        chk("t3_rdy1", 32'(recv_rdy_v[0]), 32'd0);
        step(); chk("t3_w2", send_msg_v[0], 32'h33);
        chk("t3_rdy2", 32'(recv_rdy_v[0]), 32'd0);
`ifndef PARALLEL_SERIALIZER_BACK_TO_BACK_EN
        step(); chk("t3_rdy3", 32'(recv_rdy_v[0]), 32'd0);
        recv_val_v[0] = 1'b0;
`else
        step(); recv_val_v[0] = 1'b0;
`endif
        chk("t3_w3", send_msg_v[0], 32'h44);
        step();

        // Reset mid-bundle after word 1 has gone out
        recv_msg_a    = {32'h44, 32'h33, 32'h22, 32'h11};
        recv_val_v[0] = 1'b1;
        step();
        recv_val_v[0] = 1'b0;
        chk("t4_w0", send_msg_v[0], 32'h11);
        step(); chk("t4_w1", send_msg_v[0], 32'h22);
        step(); reset = 1'b1;
        #1;
        chk("t4_rdy_in_reset", 32'(recv_rdy_v[0]), 32'd0);
        step(); reset = 1'b0;
        #1;
        chk("t4_val_after_reset", 32'(send_val_v[0]), 32'd0);
        chk("t4_rdy_after_reset", 32'(recv_rdy_v[0]), 32'd1);
        recv_msg_a    = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        recv_val_v[0] = 1'b1;
        step();
        recv_val_v[0] = 1'b0;
        chk("t4_new_w0", send_msg_v[0], 32'hA0);
        step(); chk("t4_new_w1", send_msg_v[0], 32'hA1);
        step(); step(); step();

        // Second bundle offered while the last word of the first goes out
        recv_msg_a    = {32'h44, 32'h33, 32'h22, 32'h11};
        recv_val_v[0] = 1'b1;
        step();
        recv_val_v[0] = 1'b0;
        chk("t5_w0", send_msg_v[0], 32'h11);
        step(); chk("t5_w1", send_msg_v[0], 32'h22);
        step(); chk("t5_w2", send_msg_v[0], 32'h33);
        step(); chk("t5_w3", send_msg_v[0], 32'h44);
        recv_msg_a    = {32'h58, 32'h57, 32'h56, 32'h55};
        recv_val_v[0] = 1'b1;
        #1;
`ifdef PARALLEL_SERIALIZER_BACK_TO_BACK_EN
        chk("t5_chain_rdy", 32'(recv_rdy_v[0]), 32'd1);
        step();
`else
        chk("t5_chain_rdy", 32'(recv_rdy_v[0]), 32'd0);
        step();
        chk("t5_bubble_val", 32'(send_val_v[0]), 32'd0);
        step();
`endif
        recv_val_v[0] = 1'b0;
        chk("t5_n0", send_msg_v[0], 32'h55);
        chk("t5_n0_val", 32'(send_val_v[0]), 32'd1);
        step(); chk("t5_n1", send_msg_v[0], 32'h56);
        step(); chk("t5_n2", send_msg_v[0], 32'h57);
        step(); chk("t5_n3", send_msg_v[0], 32'h58);
        step();

        // N_SAMPLES=2: two bundles, strict word order
        recv_msg_b    = {32'hB1, 32'hB0};
        recv_val_v[1] = 1'b1;
        step();
        recv_msg_b = {32'hC1, 32'hC0};
        chk("t6_w0", send_msg_v[1], 32'hB0);
        step(); chk("t6_w1", send_msg_v[1], 32'hB1);
`ifdef PARALLEL_SERIALIZER_BACK_TO_BACK_EN
        chk("t6_chain_rdy", 32'(recv_rdy_v[1]), 32'd1);
        step();
`else
        step();
        chk("t6_idle_rdy", 32'(recv_rdy_v[1]), 32'd1);
        step();
`endif
        recv_val_v[1] = 1'b0;
        chk("t6_w0n", send_msg_v[1], 32'hC0);
        step(); chk("t6_w1n", send_msg_v[1], 32'hC1);
        step(); step();

        // Randomized traffic on both instances, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            step();
            reset         = ($urandom_range(0, 199) == 0);
            recv_msg_a    = {$urandom, $urandom, $urandom, $urandom};
            recv_msg_b    = {$urandom, $urandom};
            recv_val_v[0] = ($urandom_range(0, 3) != 0);
            recv_val_v[1] = ($urandom_range(0, 2) == 0);
            send_rdy_v[0] = ($urandom_range(0, 3) != 0);
            send_rdy_v[1] = ($urandom_range(0, 1) == 0);
        end

        // Drain
        step();
        reset         = 1'b0;
        recv_val_v[0] = 1'b0;
        recv_val_v[1] = 1'b0;
        send_rdy_v[0] = 1'b1;
        send_rdy_v[1] = 1'b1;
        repeat (10) step();
        chk("drain_a_idle", 32'(send_val_v[0]), 32'd0);
        chk("drain_b_idle", 32'(send_val_v[1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
